pulse_recv: RTL
===============

// Module: pulse_recv
// PURPOSE
//  Receiving end of the toggle-based pulse crossing. A source-domain block flips a level once
//  per event; this block sits in the destination domain (clocked by src_clk). It:
//  - synchronises the incoming toggle level
//  - turns each level change back into one event
//  - queues events in a saturating counter, drained by a valid/ready handshake
//  - flags events lost to overflow.
// PARAMETERS
//  SYNC_STAGES  2  flops in toggle synchroniser chain; legal values >= 2
//  CNT_W        4  width of pending-event counter; max pending = 2**CNT_W-1
// PORTS
//  src_clk        in   1      block clock (destination-domain clock of the crossing)
//  src_reset      in   1      asynchronous, active-low reset
//  toggle_in      in   1      async toggle level from far domain; one flip = one event
//  evt_ready      in   1      consumer accepts an event this cycle when evt_valid=1
//  clr_ovf        in   1      synchronous clear of ovf_flag
//  evt_valid      out  1      at least one event pending
//  pending_cnt    out  CNT_W  number of events pending
//  ovf_flag       out  1      sticky: an edge arrived while counter saturated
//  ack_toggle_out out  1      (only with PULSE_RECV_ACK_EN) ack level returned to sender
// BEHAVIOUR
//  Reset (src_reset=0, async):
//  - synchroniser chain, edge-detect flop, counter, ovf_flag and ack_toggle_out all clear to 0
//  - so evt_valid=0 and pending_cnt=0
//  - toggle_in must be 0 at reset release (sender is reset to 0)
//  Synchronizer and edge detect:
//  - sync[0] samples toggle_in; sync[SYNC_STAGES-1] is the stable level s
//  - flop p <= s; edge = s ^ p, a 1-cycle internal pulse
//  - exactly one edge per toggle_in flip
//  - flips closer than SYNC_STAGES+1 cycles apart are not guaranteed; the sender must space events
//  Counter (registered):
//  - inc = edge; dec = evt_valid & evt_ready
//  - inc & !dec: cnt+1 if cnt != max, else cnt unchanged and ovf_flag <= 1
//  - !inc & dec: cnt-1
//  - inc & dec: cnt unchanged, including at max; no overflow in this case
//  - evt_ready while evt_valid=0 is ignored; no underflow, counter never wraps
//  Outputs:
//  - evt_valid = (cnt != 0); pending_cnt = cnt; both combinational from the counter register
//  - Latency: toggle_in flip to evt_valid=1 (counter was 0) = SYNC_STAGES+1 src_clk rising edges
//  - Handshake: event consumed on the cycle evt_valid & evt_ready are both 1
//  - evt_valid stays high while cnt>0, with no bubble between back-to-back events
//  ovf_flag:
//  - set has priority over clr_ovf when both occur in the same cycle
//  - otherwise clr_ovf=1 clears it on the next edge
//  Reset mid-operation:
//  - pending events are discarded and ovf_flag clears
//  - a toggle flip in flight during reset is lost by design
// CONFIGURATION
//  PULSE_RECV_ACK_EN defined:
//  - ack_toggle_out port exists; registered copy of p (ack_toggle_out <= p)
//  - follows toggle_in by SYNC_STAGES+2 cycles
//  - sender may compare ack against its own toggle to know the event landed (closed-loop)
//  PULSE_RECV_ACK_EN undefined:
//  - port and flop are absent; open-loop receiver; all other behaviour identical
// TESTING
//  - Reset: hold src_reset=0 with toggle_in=0, release -> evt_valid=0, pending_cnt=0, ovf_flag=0
//  - Single event, SYNC_STAGES=2, evt_ready=0: flip toggle_in 0->1 -> evt_valid=1 on 3rd edge,
//    pending_cnt=1; then evt_ready=1 for 1 cycle -> pending_cnt=0, evt_valid=0
//  - Burst, CNT_W=4, evt_ready=0: 15 flips spaced 4 cycles -> pending_cnt=15, ovf_flag=0;
//    16th flip -> pending_cnt=15, ovf_flag=1; clr_ovf pulse -> ovf_flag=0
//  - Simultaneous: cnt=15, edge arrives with evt_ready=1 -> pending_cnt stays 15, ovf_flag=0;
//    ovf set coincident with clr_ovf -> ovf_flag=1
//  - Drain: cnt=5, evt_ready held 1 -> evt_valid high 5 consecutive cycles, then 0, cnt never wraps
//  - Reset mid-run with cnt=7 and ovf_flag=1 -> all outputs 0 immediately (async);
//    with PULSE_RECV_ACK_EN, after reset and one flip -> ack_toggle_out=1 four cycles later

Source files
------------

// File: rtl/pulse_recv_if.sv
// Event handshake bundle between the pulse receiver (master) and its consumer (slave).
interface pulse_recv_if #(
  parameter int unsigned CNT_W = 4
) ();
  logic             evt_valid;
  logic             evt_ready;
  logic [CNT_W-1:0] pending_cnt;

  modport master (
    output evt_valid,
    output pending_cnt,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  pending_cnt,
    output evt_ready
  );
endinterface

// File: rtl/pulse_recv.sv
// Receiving end of a toggle-based pulse crossing: synchronise, edge-detect, count, drain.
// Optional closed-loop ack level is enabled by defining PULSE_RECV_ACK_EN.
module pulse_recv #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 4
) (
  input  logic              src_clk,
  input  logic              src_reset,
  input  logic              toggle_i,
  input  logic              clr_ovf_i,
  pulse_recv_if.master      evt_if,
  output logic              ovf_flag_o
`ifdef PULSE_RECV_ACK_EN
  ,
  output logic              ack_toggle_o
`endif
);

  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   p_q;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   ovf_q, ovf_d;
  logic                   lvl_s;
  logic                   edge_det;
  logic                   inc, dec;

  assign lvl_s    = sync_q[SYNC_STAGES-1];
  assign edge_det = lvl_s ^ p_q;
  assign inc      = edge_det;
  assign dec      = evt_if.evt_valid & evt_if.evt_ready;

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (clr_ovf_i) begin
      ovf_d = 1'b0;
    end
    if (inc && !dec) begin
      if (cnt_q != CntMax) begin
        cnt_d = cnt_q + CntOne;
      end else begin
        // Saturated: the event is dropped; set wins over a coincident clear.
        ovf_d = 1'b1;
      end
    end else if (!inc && dec) begin
      cnt_d = cnt_q - CntOne;
    end
  end

  always_ff @(posedge src_clk or negedge src_reset) begin
    if (!src_reset) begin
      sync_q <= '0;
      p_q    <= 1'b0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], toggle_i};
      p_q    <= lvl_s;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
    end
  end

  assign evt_if.evt_valid   = (cnt_q != '0);
  assign evt_if.pending_cnt = cnt_q;
  assign ovf_flag_o         = ovf_q;

`ifdef PULSE_RECV_ACK_EN
  logic ack_q;

  always_ff @(posedge src_clk or negedge src_reset) begin
    if (!src_reset) begin
      ack_q <= 1'b0;
    end else begin
      ack_q <= p_q;
    end
  end

  assign ack_toggle_o = ack_q;
`endif

endmodule
